// File: rtl/operand_fwd_ctrl.sv
// EX-stage forwarding/load-use controller: selects registered 1 cycle after issue acceptance; slots and selects freeze on stall_i.
// Backpressure: issue_ready_o drops on stall_i or a load-use hazard. FWD_PERF_CNT_EN adds stall/forward perf counters.
module operand_fwd_ctrl #(
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_rd_we_i,
  input  logic                  issue_is_load_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  issue_ready_o,
  output logic                  hazard_stall_o,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]           perf_lu_stall_o,
  output logic [31:0]           perf_fwd_o,
`endif
  output logic [1:0]            fwd_sel_a_o,
  output logic [1:0]            fwd_sel_b_o
);

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } slot_t;

  slot_t       slot_q [4];
  slot_t       s0_d;
  logic [1:0]  sel_a_q, sel_a_d;
  logic [1:0]  sel_b_q, sel_b_d;
  logic        lu_hit;
  logic        accept;

  function automatic logic writes(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.vld && s.we && (s.rd == r) && (r != '0);
  endfunction

  // Youngest producer wins: old S0 lands in MEM, old S1 in WB, old S2 is the retired write.
  function automatic logic [1:0] sel_for(slot_t s0, slot_t s1, slot_t s2,
                                         logic [REG_ADDR_W-1:0] r);
    if (writes(s0, r))      return 2'b01;
    else if (writes(s1, r)) return 2'b10;
    else if (writes(s2, r)) return 2'b11;
    else                    return 2'b00;
  endfunction

  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((k < LOAD_USE_BUBBLES) && slot_q[k].ld &&
          (writes(slot_q[k], issue_rs1_i) || writes(slot_q[k], issue_rs2_i)))
        lu_hit = 1'b1;
    end
  end

  assign hazard_stall_o = issue_valid_i && !flush_i && lu_hit;
  assign issue_ready_o  = !stall_i && !hazard_stall_o;
  assign accept         = issue_valid_i && issue_ready_o && !flush_i;

  always_comb begin
    s0_d    = '0;
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (accept) begin
      s0_d.vld = 1'b1;
      s0_d.rd  = issue_rd_i;
      s0_d.we  = issue_rd_we_i;
      s0_d.ld  = issue_is_load_i;
      sel_a_d  = sel_for(slot_q[0], slot_q[1], slot_q[2], issue_rs1_i);
      sel_b_d  = sel_for(slot_q[0], slot_q[1], slot_q[2], issue_rs2_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
    end else if (!stall_i) begin
      slot_q[3] <= slot_q[2];
      slot_q[2] <= slot_q[1];
      slot_q[1] <= slot_q[0];
      slot_q[0] <= s0_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign fwd_sel_a_o = sel_a_q;
  assign fwd_sel_b_o = sel_b_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, fwd_cnt_q;
  logic [31:0] fwd_inc;

  assign fwd_inc = {31'd0, (sel_a_d != 2'b00)} + {31'd0, (sel_b_d != 2'b00)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else if (!stall_i) begin
      lu_cnt_q  <= lu_cnt_q + {31'd0, hazard_stall_o};
      fwd_cnt_q <= fwd_cnt_q + fwd_inc;
    end
  end

  assign perf_lu_stall_o = lu_cnt_q;
  assign perf_fwd_o      = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed table-driven bench for operand_fwd_ctrl plus hand-written async-reset sequence.
module tb_operand_fwd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       issue_valid_i;
  logic [4:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic       issue_rd_we_i, issue_is_load_i;
  logic       stall_i, flush_i;
  logic       issue_ready_o, hazard_stall_o;
  logic [1:0] fwd_sel_a_o, fwd_sel_b_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_lu_stall_o, perf_fwd_o;
`endif

  operand_fwd_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_rd_i     (issue_rd_i),
    .issue_rd_we_i  (issue_rd_we_i),
    .issue_is_load_i(issue_is_load_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .issue_ready_o  (issue_ready_o),
    .hazard_stall_o (hazard_stall_o),
`ifdef FWD_PERF_CNT_EN
    .perf_lu_stall_o(perf_lu_stall_o),
    .perf_fwd_o     (perf_fwd_o),
`endif
    .fwd_sel_a_o    (fwd_sel_a_o),
    .fwd_sel_b_o    (fwd_sel_b_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2, rd;
    logic       we, ld, stall, flush;
    logic       hz, rdy;
    logic [1:0] a, b;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic vld, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic we, logic ld, logic stall, logic flush,
                              logic hz, logic rdy, logic [1:0] a, logic [1:0] b);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.ld = ld;
    v.stall = stall; v.flush = flush; v.hz = hz; v.rdy = rdy; v.a = a; v.b = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic stall, input logic flush);
    issue_valid_i = vld; issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd;
    issue_rd_we_i = we; issue_is_load_i = ld; stall_i = stall; flush_i = flush;
  endtask

  int exp_lu  = 0;
  int exp_fwd = 0;

  initial begin
    //            vld rs1 rs2 rd  we ld st fl   hz rdy a  b
    vecs.push_back(mk(1, 1,  2,  5, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 5,  5,  6, 1, 0, 0, 0,  0, 1, 1, 1));
    vecs.push_back(mk(1, 0,  0,  7, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0, 10, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 7,  0, 11, 1, 0, 0, 0,  0, 1, 2, 0));
    vecs.push_back(mk(1, 0,  0, 12, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0, 13, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0, 14, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 12, 14, 15, 1, 0, 0, 0, 0, 1, 3, 1));
    vecs.push_back(mk(1, 12, 0, 16, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 1,  0,  8, 1, 1, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 8,  1,  9, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 8,  1,  9, 1, 0, 0, 0,  0, 1, 2, 0));
    vecs.push_back(mk(1, 0,  0,  3, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0,  3, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 3,  3, 17, 1, 0, 0, 0,  0, 1, 1, 1));
    vecs.push_back(mk(1, 0,  0,  0, 1, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  3, 18, 1, 0, 0, 0,  0, 1, 0, 3));
    vecs.push_back(mk(1, 18, 17, 20, 1, 0, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(1, 20, 0, 21, 1, 0, 1, 0,  0, 0, 1, 3));
    vecs.push_back(mk(1, 20, 0, 21, 1, 0, 1, 0,  0, 0, 1, 3));
    vecs.push_back(mk(1, 20, 0, 21, 1, 0, 1, 1,  0, 0, 1, 3));
    vecs.push_back(mk(1, 20, 18, 21, 1, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 21, 20, 22, 1, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 21, 22, 19, 1, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 0,  0, 23, 1, 1, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 23, 0, 24, 1, 0, 1, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 23, 0, 24, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 23, 23, 24, 1, 0, 0, 0, 0, 1, 2, 2));
    vecs.push_back(mk(1, 0,  0, 25, 0, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 25, 24, 27, 1, 0, 0, 0, 0, 1, 0, 2));

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_sel_a", {30'd0, fwd_sel_a_o}, 0);
    chk("rst_sel_b", {30'd0, fwd_sel_b_o}, 0);
    chk("rst_hz", {31'd0, hazard_stall_o}, 0);
    chk("rst_rdy", {31'd0, issue_ready_o}, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      drive(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].we, vecs[i].ld, vecs[i].stall, vecs[i].flush);
      #1;
      chk($sformatf("v%0d_hz", i), {31'd0, hazard_stall_o}, {31'd0, vecs[i].hz});
      chk($sformatf("v%0d_rdy", i), {31'd0, issue_ready_o}, {31'd0, vecs[i].rdy});
      if (!vecs[i].stall) begin
        exp_lu  += vecs[i].hz ? 1 : 0;
        exp_fwd += ((vecs[i].a != 2'b00) ? 1 : 0) + ((vecs[i].b != 2'b00) ? 1 : 0);
      end
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_sel_a", i), {30'd0, fwd_sel_a_o}, {30'd0, vecs[i].a});
      chk($sformatf("v%0d_sel_b", i), {30'd0, fwd_sel_b_o}, {30'd0, vecs[i].b});
    end

`ifdef FWD_PERF_CNT_EN
    chk("perf_lu", perf_lu_stall_o, exp_lu);
    chk("perf_fwd", perf_fwd_o, exp_fwd);
`endif

    // Async reset between edges with a load sitting in S0.
    @(negedge clk_i);
    drive(1, 0, 0, 26, 1, 1, 0, 0);
    @(posedge clk_i);
    #1;
    drive(1, 26, 0, 28, 1, 0, 0, 0);
    #1;
    chk("pre_rst_hz", {31'd0, hazard_stall_o}, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_hz", {31'd0, hazard_stall_o}, 0);
    chk("arst_rdy", {31'd0, issue_ready_o}, 1);
    chk("arst_sel_a", {30'd0, fwd_sel_a_o}, 0);
    chk("arst_sel_b", {30'd0, fwd_sel_b_o}, 0);
    stall_i = 1'b1;
    #1;
    chk("arst_rdy_stall", {31'd0, issue_ready_o}, 0);
`ifdef FWD_PERF_CNT_EN
    chk("arst_perf_lu", perf_lu_stall_o, 0);
    chk("arst_perf_fwd", perf_fwd_o, 0);
`endif

    // First edge after release is a normal advance.
    @(negedge clk_i);
    drive(1, 26, 0, 28, 1, 0, 0, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_sel_a", {30'd0, fwd_sel_a_o}, 0);
    @(negedge clk_i);
    drive(1, 28, 28, 29, 1, 0, 0, 0);
    #1;
    chk("post_rst_hz", {31'd0, hazard_stall_o}, 0);
    @(posedge clk_i);
    #1;
    chk("post_rst_fwd_a", {30'd0, fwd_sel_a_o}, 1);
    chk("post_rst_fwd_b", {30'd0, fwd_sel_b_o}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
